// File: rtl/facto_pkg.sv
// Shared types and step constants for the iterative factorial engine.
package facto_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic {MODE_FACT = 1'b0, MODE_DFACT = 1'b1} mode_t;

  localparam int unsigned STEP_FACT  = 1;
  localparam int unsigned STEP_DFACT = 2;

  function automatic int unsigned step_of(mode_t m);
    return (m == MODE_DFACT) ? STEP_DFACT : STEP_FACT;
  endfunction

endpackage

// File: rtl/facto_mul_step.sv
// One multiply step of the factorial loop: truncated product plus sticky overflow.
module facto_mul_step #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned X_W    = 5
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [X_W-1:0]    cnt_i,
  input  logic              ovf_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic              ovf_next_o
);

  logic [DATA_W+X_W-1:0] prod;

  always_comb begin
    prod       = {{X_W{1'b0}}, acc_i} * {{DATA_W{1'b0}}, cnt_i};
    acc_next_o = prod[DATA_W-1:0];
    // Any bit above the accumulator width means the true value no longer fits.
    ovf_next_o = ovf_i | (prod[DATA_W+X_W-1:DATA_W] != '0);
  end

endmodule

// File: rtl/facto_engine.sv
// Iterative x! / x!! engine with start/ready handshake, abort and overflow detection.
module facto_engine
  import facto_pkg::*;
#(
  parameter int unsigned X_W      = 5,
  parameter int unsigned DATA_W   = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [X_W-1:0]    x_i,
  input  logic              mode_i,
  input  logic              abort_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              overflow_o
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [X_W-1:0]    cnt_q, cnt_d;
  logic [X_W-1:0]    step_q, step_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] acc_next;
  logic              ovf_next;

  facto_mul_step #(
    .DATA_W(DATA_W),
    .X_W   (X_W)
  ) u_mul_step (
    .acc_i     (acc_q),
    .cnt_i     (cnt_q),
    .ovf_i     (ovf_q),
    .acc_next_o(acc_next),
    .ovf_next_o(ovf_next)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d   = DATA_W'(1);
          cnt_d   = x_i;
          step_d  = X_W'(step_of(mode_t'(mode_i)));
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q <= X_W'(1)) begin
          state_d    = DONE;
          result_d   = (SATURATE && ovf_q) ? '1 : acc_q;
          overflow_d = ovf_q;
        end else begin
          // cnt_q >= 2 here, so subtracting the step cannot wrap.
          acc_d = acc_next;
          ovf_d = ovf_next;
          cnt_d = cnt_q - step_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      step_q     <= X_W'(STEP_FACT);
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign busy_o     = (state_q == CALC);
  assign done_o     = (state_q == DONE);
  assign result_o   = result_q;
  assign overflow_o = overflow_q;

endmodule
